// File: rtl/jtframe_rom_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | jtframe_arb_pkg : state encoding and default timing for the ROM arbiter     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package jtframe_arb_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    WAIT_ACK  = ST_WAIT_ACK,
    WAIT_DATA = ST_WAIT_DATA
  } arb_state_t;

  localparam int DEF_RFSH_PERIOD = 384;
  localparam int DEF_READY_DLY   = 16;

endpackage

`default_nettype wire

// File: rtl/jtframe_rom_arb_rr_pick.sv
// +----------------------------------------------------------------------------+
// | jtframe_rr_pick : combinational round-robin picker, search starts at ptr    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtframe_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  onehot
);

  logic found;

  assign any = |valid;

  // Step i of the search looks at client (ptr+i) mod N; the first hit wins.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && valid[j] &&
            ((int'(ptr) + i == j) || (int'(ptr) + i == j + N))) begin
          onehot[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtframe_rom_arb.sv
// +----------------------------------------------------------------------------+
// | jtframe_rom_arb : round-robin SDRAM read arbiter for romrq clients+refresh  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtframe_rom_arb
  import jtframe_arb_pkg::*;
#(
  parameter int N           = 3,
  parameter int AW          = 22,
  parameter int RFSH_PERIOD = DEF_RFSH_PERIOD,
  parameter int READY_DLY   = DEF_READY_DLY
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic            loop_rst,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] addr,
  output logic [N-1:0]    data_sel,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  output logic            refresh_en,
  input  logic            rfsh_ack,
  output logic            ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
  localparam int RW = $clog2(READY_DLY + 1);
  localparam logic [CW-1:0] RFSH_LOAD = CW'(RFSH_PERIOD - 1);
  localparam logic [RW-1:0] RDY_LAST  = RW'(READY_DLY - 1);

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [CW-1:0] rfsh_cnt;
  logic          rfsh_pend;
  logic [RW-1:0] rdy_cnt;

  logic [N-1:0]  valid;
  logic [N-1:0]  pick_oh;
  logic          pick_any;
  logic [AW-1:0] pick_addr;
  logic [PW-1:0] pick_next;
  logic          clear;
  logic          done;
  logic          grant_ok;

  assign clear = downloading | loop_rst;

  // data_sel still marks the served client during its data_rdy cycle,
  // which keeps it out of the back-to-back pick while its req decays.
  assign valid    = req & ~data_sel;
  assign done     = (state != IDLE) && data_rdy;
  assign grant_ok = !rfsh_pend && pick_any;

  assign refresh_en = (state == IDLE) && (rfsh_pend || !pick_any);

  jtframe_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .valid  (valid),
    .ptr    (ptr),
    .any    (pick_any),
    .onehot (pick_oh)
  );

  always_comb begin
    pick_addr = '0;
    pick_next = '0;
    for (int j = 0; j < N; j++) begin
      if (pick_oh[j]) begin
        pick_addr = addr[j*AW +: AW];
        pick_next = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_sel   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      rfsh_pend  <= 1'b0;
      rfsh_cnt   <= RFSH_LOAD;
      ptr        <= '0;
      ready      <= 1'b0;
      rdy_cnt    <= '0;
    end else if (clear) begin
      state      <= IDLE;
      data_sel   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      rfsh_pend  <= 1'b0;
      rfsh_cnt   <= RFSH_LOAD;
      ptr        <= '0;
      ready      <= 1'b0;
      rdy_cnt    <= '0;
    end else begin
      // A new period starting on the ack cycle keeps the request pending.
      if (rfsh_cnt == '0) begin
        rfsh_cnt  <= RFSH_LOAD;
        rfsh_pend <= 1'b1;
      end else begin
        rfsh_cnt <= rfsh_cnt - 1'b1;
        if (rfsh_ack) rfsh_pend <= 1'b0;
      end

      if (!ready) begin
        rdy_cnt <= rdy_cnt + 1'b1;
        if (rdy_cnt == RDY_LAST) ready <= 1'b1;
      end

      if ((state == IDLE || done) && grant_ok) begin
        state      <= WAIT_ACK;
        sdram_req  <= 1'b1;
        sdram_addr <= pick_addr;
        data_sel   <= pick_oh;
        ptr        <= pick_next;
      end else if (done) begin
        state     <= IDLE;
        sdram_req <= 1'b0;
        data_sel  <= '0;
      end else if (state == WAIT_ACK && sdram_ack) begin
        state     <= WAIT_DATA;
        sdram_req <= 1'b0;
      end else if (state != IDLE && state != WAIT_ACK && state != WAIT_DATA) begin
        state <= IDLE;
      end
    end
  end

endmodule

`default_nettype wire
